// File: rtl/control_sequencer.sv
// Hardwired control unit: sequences fetch (T0-T2), decodes the IR opcode and
// runs a three-step register-register ALU execute (T3-T5), driving the
// datapath strobes.
// Ports:
//   clock, clear       - rising-edge clock, asynchronous active-low reset
//   ir[31:0]           - datapath IR (opcode ir[31:27]; Ra/Rb/Rc are decoded in the datapath)
//   mem_ready          - memory read data valid this cycle
//   PCout..Rout        - bus drive enables
//   MARin..Rin         - register load enables
//   IncPC, Read        - PC increment select, memory read strobe
//   Gra, Grb, Grc      - register-field selects
//   ADD..NOT           - ALU operation (one-hot or zero)
//   run                - high while T0-T5 are executing
//   fault              - sticky memory wait timeout flag
module control_sequencer #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Rout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        NOT,
    output logic        run,
    output logic        fault
);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [2:0] {
        RST, T0, T1, T2, T3, T4, T5, HALT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic               fault_nxt;
    logic [4:0]         opcode;

    assign opcode = ir[31:27];

    // Register fields are consumed by the datapath select/encode logic.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[26:0];

    // State, wait counter and sticky fault.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= RST;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            fault    <= fault_nxt;
        end
    end

    // Next state and Moore strobes; T3/T4 strobes additionally decode the opcode.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        fault_nxt    = fault;
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Rout = 1'b0;
        MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Rin = 1'b0;
        IncPC = 1'b0; Read = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0; NOT = 1'b0;
        run = 1'b0;

        case (state)
            RST: state_nxt = T0;
            T0: begin
                run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                // A ready on the limit cycle still completes the fetch.
                if (mem_ready) begin
                    state_nxt    = T2;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == CNT_W'(WAIT_LIMIT)) begin
                    state_nxt    = HALT;
                    wait_cnt_nxt = '0;
                    fault_nxt    = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            T2: begin
                run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                run = 1'b1;
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        state_nxt = T4;
                    end
                    OP_NOT:  state_nxt = T4;
                    OP_HALT: state_nxt = HALT;
                    default: state_nxt = T0;
                endcase
            end
            T4: begin
                run = 1'b1;
                case (opcode)
                    OP_ADD: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ADD = 1'b1; end
                    OP_SUB: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; SUB = 1'b1; end
                    OP_AND: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; AND = 1'b1; end
                    OP_OR:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; OR  = 1'b1; end
                    OP_NOT: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; NOT = 1'b1; end
                    default: ;
                endcase
                state_nxt = T5;
            end
            T5: begin
                run = 1'b1; Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                state_nxt = T0;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: expected per-cycle strobe vectors
// are generated from the instruction class and the chosen memory wait count.
module tb_control_sequencer;

    localparam int unsigned WAIT_LIMIT = 15;

    typedef logic [22:0] vec_t;

    localparam vec_t M_PCOUT  = vec_t'(1 << 22);
    localparam vec_t M_ZLOW   = vec_t'(1 << 21);
    localparam vec_t M_MDROUT = vec_t'(1 << 20);
    localparam vec_t M_ROUT   = vec_t'(1 << 19);
    localparam vec_t M_MARIN  = vec_t'(1 << 18);
    localparam vec_t M_PCIN   = vec_t'(1 << 17);
    localparam vec_t M_MDRIN  = vec_t'(1 << 16);
    localparam vec_t M_IRIN   = vec_t'(1 << 15);
    localparam vec_t M_YIN    = vec_t'(1 << 14);
    localparam vec_t M_ZIN    = vec_t'(1 << 13);
    localparam vec_t M_RIN    = vec_t'(1 << 12);
    localparam vec_t M_INCPC  = vec_t'(1 << 11);
    localparam vec_t M_READ   = vec_t'(1 << 10);
    localparam vec_t M_GRA    = vec_t'(1 << 9);
    localparam vec_t M_GRB    = vec_t'(1 << 8);
    localparam vec_t M_GRC    = vec_t'(1 << 7);
    localparam vec_t M_ADD    = vec_t'(1 << 6);
    localparam vec_t M_SUB    = vec_t'(1 << 5);
    localparam vec_t M_AND    = vec_t'(1 << 4);
    localparam vec_t M_OR     = vec_t'(1 << 3);
    localparam vec_t M_NOT    = vec_t'(1 << 2);
    localparam vec_t M_RUN    = vec_t'(1 << 1);
    localparam vec_t M_FAULT  = vec_t'(1);

    localparam vec_t V_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
    localparam vec_t V_T1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam vec_t V_T2 = M_MDROUT | M_IRIN | M_RUN;
    localparam vec_t V_T5 = M_ZLOW | M_GRA | M_RIN | M_RUN;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic PCout, Zlowout, MDRout, Rout, MARin, PCin, MDRin, IRin, Yin, Zin, Rin;
    logic IncPC, Read, Gra, Grb, Grc, ADD, SUB, AND, OR, NOT, run, fault;

    vec_t  act;
    vec_t  exp_vec = '0;
    bit    exp_valid = 1'b0;
    string exp_name = "reset";
    int    total = 0;
    int    bad = 0;

    control_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(4)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Rin(Rin), .IncPC(IncPC), .Read(Read), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
        .NOT(NOT), .run(run), .fault(fault)
    );

    assign act = {PCout, Zlowout, MDRout, Rout, MARin, PCin, MDRin, IRin, Yin,
                  Zin, Rin, IncPC, Read, Gra, Grb, Grc, ADD, SUB, AND, OR, NOT,
                  run, fault};

    always #5 clock = ~clock;

    task automatic chk(input string name, input vec_t got, input vec_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic chk_onehot0(input string name, input logic [4:0] bits);
        total++;
        if (!$onehot0(bits)) begin
            bad++;
            $display("FAIL %s got=%b want=onehot0 t=%0t", name, bits, $time);
        end
    endtask

    // Per-cycle comparison against the expected vector plus the invariants.
    always @(negedge clock) begin
        if (exp_valid) begin
            chk(exp_name, act, exp_vec);
            chk_onehot0("bus_drivers", {1'b0, act[22:19]});
            chk_onehot0("alu_strobes", act[6:2]);
            chk_onehot0("reg_selects", {2'b00, act[9:7]});
        end
    end

    // Instruction classes: 0 binary ALU, 1 not, 2 halt, 3 nop/illegal.
    function automatic int op_kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return 0;
            5'b10010: return 1;
            5'b11011: return 2;
            default:  return 3;
        endcase
    endfunction

    function automatic vec_t alu_mask(input logic [4:0] op);
        case (op)
            5'b00011: return M_ADD;
            5'b00100: return M_SUB;
            5'b00101: return M_AND;
            5'b00110: return M_OR;
            default:  return M_NOT;
        endcase
    endfunction

    // Execute-phase expectations for steps 3..5.
    function automatic vec_t exec_vec(input logic [4:0] op, input int step);
        int k;
        k = op_kind(op);
        if (step == 5) return V_T5;
        if (step == 3) return (k == 0) ? (M_GRB | M_ROUT | M_YIN | M_RUN) : M_RUN;
        if (k == 0) return M_GRC | M_ROUT | M_ZIN | alu_mask(op) | M_RUN;
        return M_GRB | M_ROUT | M_NOT | M_ZIN | M_RUN;
    endfunction

    task automatic cyc(input string name, input vec_t v, input logic mr, input logic [31:0] irv);
        @(posedge clock);
        #1;
        mem_ready = mr;
        ir        = irv;
        exp_vec   = v;
        exp_name  = name;
    endtask

    task automatic release_clear();
        @(posedge clock);
        #1;
        clear    = 1'b1;
        exp_vec  = '0;
        exp_name = "RST";
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        clear    = 1'b0;
        exp_vec  = '0;
        exp_name = "clear_low";
        release_clear();
    endtask

    task automatic halt_cycles(input bit f);
        repeat (3) cyc("HALT", f ? M_FAULT : vec_t'(0), 1'($urandom), $urandom);
        do_reset();
    endtask

    // Drives one instruction; k is the number of mem_ready=0 cycles in T1.
    task automatic run_instr(input logic [31:0] irv, input int k, input bit abort_t4);
        logic [4:0] op;
        bit mr, timed_out;
        op = irv[31:27];
        cyc("T0", V_T0, 1'($urandom), $urandom);
        timed_out = 1'b1;
        for (int j = 0; j <= int'(WAIT_LIMIT); j++) begin
            mr = (j >= k);
            cyc("T1", V_T1, mr, $urandom);
            if (mr) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (timed_out) begin
            halt_cycles(1'b1);
            return;
        end
        cyc("T2", V_T2, 1'($urandom), $urandom);
        case (op_kind(op))
            2: begin
                cyc("T3_halt", M_RUN, 1'($urandom), irv);
                halt_cycles(1'b0);
            end
            3: cyc("T3_nop", M_RUN, 1'($urandom), irv);
            default: begin
                cyc("T3", exec_vec(op, 3), 1'($urandom), irv);
                cyc("T4", exec_vec(op, 4), 1'($urandom), irv);
                if (abort_t4) begin
                    @(negedge clock);
                    #1;
                    clear   = 1'b0;
                    exp_vec = '0;
                    exp_name = "clear_low";
                    #1;
                    chk("async_clear", act, '0);
                    release_clear();
                end else begin
                    cyc("T5", exec_vec(op, 5), 1'($urandom), $urandom);
                end
            end
        endcase
    endtask

    // Directed instruction with hand-written T3..T5 vectors and no wait.
    task automatic run_lit(input logic [31:0] irv, input vec_t v3, input vec_t v4, input vec_t v5);
        cyc("T0", V_T0, 1'b0, $urandom);
        cyc("T1", V_T1, 1'b1, $urandom);
        cyc("T2", V_T2, 1'b0, $urandom);
        cyc("lit_T3", v3, 1'b0, irv);
        cyc("lit_T4", v4, 1'b0, irv);
        cyc("lit_T5", v5, 1'b0, irv);
    endtask

    initial begin
        logic [4:0] op;
        int r, k;
        repeat (2) @(posedge clock);
        #1;
        exp_valid = 1'b1;
        exp_vec   = '0;
        exp_name  = "reset";
        release_clear();

        // and R1,R6,R7
        run_lit(32'h28B38000, M_GRB | M_ROUT | M_YIN | M_RUN,
                M_GRC | M_ROUT | M_AND | M_ZIN | M_RUN, M_ZLOW | M_GRA | M_RIN | M_RUN);
        // not R2,R3
        run_lit(32'h91180000, M_RUN, M_GRB | M_ROUT | M_NOT | M_ZIN | M_RUN,
                M_ZLOW | M_GRA | M_RIN | M_RUN);
        run_instr(32'h18000000, 3, 1'b0);   // add with 3 wait cycles
        run_instr(32'h20000000, 15, 1'b0);  // ready arrives on the limit cycle
        run_instr(32'h18000000, 40, 1'b0);  // timeout
        run_instr(32'hD0000000, 0, 1'b0);   // nop
        run_instr(32'hF8000000, 0, 1'b0);   // illegal behaves as nop
        run_instr(32'hD8000000, 0, 1'b0);   // halt
        run_instr(32'h18000000, 0, 1'b1);   // clear during T4
        cyc("T0_after_clear", M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN, 1'b1, $urandom);
        cyc("T1", V_T1, 1'b1, $urandom);
        cyc("T2", V_T2, 1'b0, $urandom);
        cyc("T3_nop", M_RUN, 1'b0, 32'hD0000000);

        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    op = 5'b00011;
                2:       op = 5'b00100;
                3:       op = 5'b00101;
                4:       op = 5'b00110;
                5:       op = 5'b10010;
                6:       op = 5'b11010;
                7:       op = ($urandom_range(0, 3) == 0) ? 5'b11011 : 5'b00011;
                default: op = 5'($urandom);
            endcase
            r = $urandom_range(0, 19);
            if (r < 15)      k = $urandom_range(0, 3);
            else if (r < 18) k = $urandom_range(13, 15);
            else             k = $urandom_range(16, 18);
            run_instr({op, 27'($urandom)}, k, ($urandom_range(0, 24) == 0));
        end

        @(posedge clock);
        #1;
        exp_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
